// File: rtl/pmp_pkg.sv
// Shared types and helpers for the sequential PMP checker.
// Entry config layout, address-match modes and scan FSM states.
package pmp_pkg;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef enum logic [1:0] {
        ACC_R   = 2'd0,
        ACC_W   = 2'd1,
        ACC_X   = 2'd2,
        ACC_BAD = 2'd3
    } pmp_acc_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_RESP
    } scan_state_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    function automatic logic [5:0] trail_ones(input logic [31:0] v);
        logic [5:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && v[i]) n = n + 6'd1;
            else             run = 1'b0;
        end
        return n;
    endfunction

    function automatic pmp_cfg_t cfg_clean(input logic [7:0] d);
        pmp_cfg_t c;
        c      = pmp_cfg_t'(d);
        c.rsvd = '0;
        return c;
    endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Single PMP entry address matcher (combinational), shared by the scan.
// TOR matching exists only when PMP_TOR_EN is defined.
module pmp_entry_match
    import pmp_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] ent_addr,
    input  pmp_a_e      ent_a,
    input  logic [31:0] prev_addr,
    output logic        hit,
    output logic        full
);

    logic [35:0] s_lo, s_hi, lo, hi, mask;
    logic        unused_prev;

    assign unused_prev = ^prev_addr;

    // 36-bit math so the all-ones NAPOT region (2^35 bytes) cannot wrap
    always_comb begin
        s_lo = {4'b0, addr};
        s_hi = s_lo + (36'd1 << size) - 36'd1;
        mask = (36'd8 << trail_ones(ent_addr)) - 36'd1;
        lo   = '0;
        hi   = '0;
        hit  = 1'b0;
        full = 1'b0;
        case (ent_a)
            A_NA4: begin
                lo   = {2'b0, ent_addr, 2'b00};
                hi   = lo + 36'd3;
                hit  = (s_lo >= lo) && (s_lo <= hi);
                full = hit && (s_hi <= hi);
            end
            A_NAPOT: begin
                lo   = {2'b0, ent_addr, 2'b00} & ~mask;
                hi   = lo | mask;
                hit  = (s_lo >= lo) && (s_lo <= hi);
                full = hit && (s_hi <= hi);
            end
`ifdef PMP_TOR_EN
            A_TOR: begin
                lo   = {2'b0, prev_addr, 2'b00};
                hi   = {2'b0, ent_addr, 2'b00};
                hit  = (s_lo >= lo) && (s_lo < hi);
                full = hit && (s_hi < hi);
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/pmp_scan_ctrl.sv
// Sequential PMP checker: scans entries one per cycle, lowest hit wins.
// Optional feature macro: PMP_TOR_EN (TOR matching and cross-entry lock).
module pmp_scan_ctrl
    import pmp_pkg::*;
#(
    parameter  int N_ENTRIES = 8,
    localparam int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_we,
    input  logic             csr_sel,
    input  logic [IDX_W-1:0] csr_idx,
    input  logic [31:0]      csr_wdata,
    output logic             csr_ready,
    output logic [31:0]      csr_rdata,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic [1:0]       req_acc,
    input  logic             req_mmode,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_fault,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ENTRIES - 1);

    scan_state_e      state;
    pmp_cfg_t         cfg_q  [N_ENTRIES];
    logic [31:0]      addr_q [N_ENTRIES];
    logic [N_ENTRIES-1:0] addr_lock;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      a_addr;
    logic [1:0]       a_size;
    logic [1:0]       a_acc;
    logic             a_mmode;
    logic             idx_ok;
    logic             m_hit, m_full;
    logic [31:0]      prev_addr;
    logic             perm, dec_fault;

    assign csr_ready = (state == S_IDLE);
    assign req_ready = (state == S_IDLE) && !csr_we;
    assign idx_ok    = 32'(csr_idx) < N_ENTRIES;

    always_comb begin
        csr_rdata = '0;
        if (idx_ok)
            csr_rdata = csr_sel ? {24'b0, cfg_q[csr_idx]} : addr_q[csr_idx];
    end

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) addr_lock[i] = cfg_q[i].l;
`ifdef PMP_TOR_EN
        for (int i = 1; i < N_ENTRIES; i++)
            if (cfg_q[i].l && cfg_q[i].a == A_TOR) addr_lock[i-1] = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (csr_we && state == S_IDLE && idx_ok) begin
            if (csr_sel) begin
                if (!cfg_q[csr_idx].l) cfg_q[csr_idx] <= cfg_clean(csr_wdata[7:0]);
            end else if (!addr_lock[csr_idx]) begin
                addr_q[csr_idx] <= csr_wdata;
            end
        end
    end

    assign prev_addr = (idx_q == '0) ? 32'd0 : addr_q[idx_q - 1'b1];

    pmp_entry_match u_match (
        .addr      (a_addr),
        .size      (a_size),
        .ent_addr  (addr_q[idx_q]),
        .ent_a     (cfg_q[idx_q].a),
        .prev_addr (prev_addr),
        .hit       (m_hit),
        .full      (m_full)
    );

    always_comb begin
        case (a_acc)
            ACC_R:   perm = cfg_q[idx_q].r;
            ACC_W:   perm = cfg_q[idx_q].w;
            ACC_X:   perm = cfg_q[idx_q].x;
            default: perm = 1'b0;
        endcase
        if (!m_full)                            dec_fault = 1'b1;
        else if (a_mmode && !cfg_q[idx_q].l)    dec_fault = 1'b0;
        else                                    dec_fault = !perm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx_q      <= '0;
            a_addr     <= '0;
            a_size     <= '0;
            a_acc      <= '0;
            a_mmode    <= 1'b0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        a_addr  <= req_addr;
                        a_size  <= req_size;
                        a_acc   <= req_acc;
                        a_mmode <= req_mmode;
                        idx_q   <= '0;
                        if (req_size == 2'd3 || req_acc == ACC_BAD) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_hit   <= 1'b0;
                            resp_idx   <= '0;
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (m_hit) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= dec_fault;
                        resp_hit   <= 1'b1;
                        resp_idx   <= idx_q;
                    end else if (idx_q == LAST) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= !a_mmode;
                        resp_hit   <= 1'b0;
                        resp_idx   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// Directed bench for pmp_scan_ctrl with an expected-response scoreboard.
// Covers both builds of PMP_TOR_EN.
module tb_pmp_scan_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          csr_we = 1'b0;
    logic          csr_sel = 1'b0;
    logic [IW-1:0] csr_idx = '0;
    logic [31:0]   csr_wdata = '0;
    logic          csr_ready;
    logic [31:0]   csr_rdata;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic [1:0]    req_size = '0;
    logic [1:0]    req_acc = '0;
    logic          req_mmode = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_fault;
    logic          resp_hit;
    logic [IW-1:0] resp_idx;

    pmp_scan_ctrl #(.N_ENTRIES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .csr_we     (csr_we),
        .csr_sel    (csr_sel),
        .csr_idx    (csr_idx),
        .csr_wdata  (csr_wdata),
        .csr_ready  (csr_ready),
        .csr_rdata  (csr_rdata),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_acc    (req_acc),
        .req_mmode  (req_mmode),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_fault (resp_fault),
        .resp_hit   (resp_hit),
        .resp_idx   (resp_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fault;
        logic          hit;
        logic [IW-1:0] idx;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic sel, input int idx, input logic [31:0] d);
        @(negedge clk);
        csr_we    = 1'b1;
        csr_sel   = sel;
        csr_idx   = IW'(idx);
        csr_wdata = d;
        @(posedge clk);
        #1;
        csr_we = 1'b0;
    endtask

    task automatic csr_rd_chk(input string tag, input logic sel, input int idx,
                              input logic [31:0] exp);
        @(negedge clk);
        csr_sel = sel;
        csr_idx = IW'(idx);
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic req(input string tag, input logic [31:0] a, input logic [1:0] sz,
                       input logic [1:0] acc, input logic mm, input logic ef,
                       input logic eh, input int ei, input int elat, input int hold);
        exp_t e;
        int   lat;
        sb.push_back('{fault: ef, hit: eh, idx: IW'(ei), lat: elat});
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = sz;
        req_acc   = acc;
        req_mmode = mm;
        #1;
        chk({tag, ".req_ready"}, req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".latency"}, lat, e.lat);
        chk({tag, ".fault"}, resp_fault, e.fault);
        chk({tag, ".hit"}, resp_hit, e.hit);
        chk({tag, ".idx"}, resp_idx, e.idx);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, resp_valid, 1);
            chk({tag, ".hold_fault"}, resp_fault, e.fault);
            chk({tag, ".hold_idx"}, resp_idx, e.idx);
            chk({tag, ".hold_req_ready"}, req_ready, 0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, ".released"}, resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.resp_fault", resp_fault, 0);
        chk("rst.resp_hit", resp_hit, 0);
        chk("rst.csr_ready", csr_ready, 1);
        chk("rst.req_ready", req_ready, 1);
        csr_rd_chk("rst.cfg0", 1'b1, 0, 32'h0);
        csr_rd_chk("rst.addr7", 1'b0, 7, 32'h0);

        // no entries enabled
        req("t1.u_read", 32'h1000, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 0, N + 1, 0);
        req("t1.m_read", 32'h1000, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 0, N + 1, 0);

        // entry3 NAPOT 8KB at 0, R only; reserved cfg bits drop
        csr_wr(1'b0, 3, 32'h0000_03FF);
        csr_wr(1'b1, 3, 32'h0000_0079);
        csr_rd_chk("t2.cfg3_clean", 1'b1, 3, 32'h19);
        req("t2.u_write", 32'h100, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1, 3, 5, 0);
        req("t2.u_read", 32'h100, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 3, 5, 0);
        req("t2.bad_size", 32'h100, 2'd3, 2'd0, 1'b1, 1'b1, 1'b0, 0, 1, 0);
        req("t2.bad_acc", 32'h100, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0, 0, 1, 0);

        // entry0 NA4 no perms at 0x2000 shadows entry1 NAPOT 16KB RWX
        csr_wr(1'b0, 0, 32'h0000_0800);
        csr_wr(1'b1, 0, 32'h0000_0010);
        csr_wr(1'b0, 1, 32'h0000_07FF);
        csr_wr(1'b1, 1, 32'h0000_001F);
        req("t3.prio", 32'h2000, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 0, 2, 0);
        req("t3.entry1", 32'h2004, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1, 3, 0);
        req("t3.miss", 32'h8000, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 0, N + 1, 0);

        // entry2 NA4 at 0x5000: partial overlap, then lock
        csr_wr(1'b0, 2, 32'h0000_1400);
        csr_wr(1'b1, 2, 32'h0000_0017);
        req("t4.partial", 32'h5002, 2'd2, 2'd0, 1'b1, 1'b1, 1'b1, 2, 4, 0);
        req("t4.m_full", 32'h5000, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2, 4, 0);
        csr_wr(1'b1, 2, 32'h0000_0091);
        req("t4.m_locked_w", 32'h5000, 2'd2, 2'd1, 1'b1, 1'b1, 1'b1, 2, 4, 0);
        csr_wr(1'b1, 2, 32'h0000_0000);
        csr_rd_chk("t4.cfg_locked", 1'b1, 2, 32'h91);
        csr_wr(1'b0, 2, 32'h0000_0000);
        csr_rd_chk("t4.addr_locked", 1'b0, 2, 32'h1400);

        // response back-pressure
        req("t5.stall", 32'h100, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 1, 3, 5);

        // CSR write wins over a simultaneous request
        @(negedge clk);
        csr_we    = 1'b1;
        csr_sel   = 1'b0;
        csr_idx   = 3'd5;
        csr_wdata = 32'h0000_ABCD;
        req_valid = 1'b1;
        req_addr  = 32'h100;
        req_size  = 2'd0;
        req_acc   = 2'd0;
        req_mmode = 1'b0;
        #1;
        chk("t5.prio_req_ready", req_ready, 0);
        chk("t5.prio_csr_ready", csr_ready, 1);
        @(posedge clk);
        #1;
        csr_we    = 1'b0;
        req_valid = 1'b0;
        chk("t5.still_idle", csr_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5.no_resp", resp_valid, 0);
        csr_rd_chk("t5.addr5", 1'b0, 5, 32'h0000_ABCD);

        // asynchronous reset mid-scan
        @(negedge clk);
        csr_sel   = 1'b1;
        csr_idx   = 3'd2;
        req_valid = 1'b1;
        req_addr  = 32'h6000;
        req_size  = 2'd2;
        req_acc   = 2'd0;
        req_mmode = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.rst_valid", resp_valid, 0);
        chk("t6.rst_csr_ready", csr_ready, 1);
        chk("t6.rst_cfg2", csr_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 3) @(posedge clk);
        #1;
        chk("t6.no_resp", resp_valid, 0);

        // entry4 TOR 0x4000..0x5000 on entry3's address
        csr_wr(1'b0, 3, 32'h0000_1000);
        csr_wr(1'b0, 4, 32'h0000_1400);
        csr_wr(1'b1, 4, 32'h0000_0009);
`ifdef PMP_TOR_EN
        req("t6.tor_hit", 32'h4FFC, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 4, 6, 0);
`else
        req("t6.tor_off", 32'h4FFC, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 0, N + 1, 0);
`endif
        req("t6.tor_miss", 32'h5000, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 0, N + 1, 0);
        csr_wr(1'b1, 4, 32'h0000_0089);
        csr_wr(1'b0, 3, 32'h0000_0123);
`ifdef PMP_TOR_EN
        csr_rd_chk("t6.prev_locked", 1'b0, 3, 32'h0000_1000);
`else
        csr_rd_chk("t6.prev_free", 1'b0, 3, 32'h0000_0123);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
